shifter_seq: RTL
================

Name: shifter_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit shifter. Supports any power-of-two width and adds rotates.
- Shifts by STEP bits per clock, trading latency for area. STEP = WIDTH gives single-step operation.
- Sits between the ALU operand bus and the writeback bus, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, datapath width. Power of two, 16 or more.
- STEP, 4, maximum bits shifted per cycle. Power of two, 1 to WIDTH.

Ports:
- CLK  input  1  clock. All state changes on rising edge.
- N_RST  input  1  asynchronous active-low reset.
- FLUSH  input  1  synchronous abort of any operation in flight.
- IN_VALID  input  1  request valid.
- IN_READY  output  1  request accepted when IN_VALID && IN_READY.
- IN  input  WIDTH  operand.
- SHFT  input  $clog2(WIDTH)  shift amount, unsigned.
- OP  input  3  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5 SEXT8, 6 SEXT16, 7 reserved (executes as SLL).
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- OUT  output  WIDTH  result register.

Behaviour:
- Registers:
  - acc[WIDTH]
  - rem[$clog2(WIDTH)]
  - op_q[3]
  - state: IDLE, SHIFT, DONE
- Reset (N_RST low, asynchronous): state=IDLE, acc=0, rem=0, op_q=0. So OUT=0 and OUT_VALID=0 immediately.
- IN_READY = N_RST && !FLUSH && (state==IDLE || (state==DONE && OUT_READY)). It is combinational and has no dependency on IN_VALID.
- OUT = acc. OUT_VALID = (state==DONE).
- Capture (handshake):
  - acc loads the pre-step value: IN for ops 0-4 and 7; {{WIDTH-8{IN[7]}},IN[7:0]} for SEXT8; {{WIDTH-16{IN[15]}},IN[15:0]} for SEXT16.
  - rem=SHFT and op_q=OP are loaded.
  - Next state is DONE if SHFT==0, else SHIFT.
- SHIFT state, per cycle:
  - n = min(STEP, rem). acc shifts by n and rem decrements by n.
  - When rem reaches 0 in this cycle, the next state is DONE.
  - Fill bits:
    - SLL, SEXT8, SEXT16: zeros enter at the LSB.
    - SRL: zeros enter at the MSB.
    - SRA: acc[WIDTH-1] enters at the MSB. The sign is invariant across steps.
    - ROL/ROR: bits wrap around.
- Latency: OUT_VALID rises exactly 1 + ceil(SHFT/STEP) cycles after the handshake cycle. SHFT=0 gives 1 cycle.
- DONE state:
  - acc, OUT and OUT_VALID hold stable while OUT_READY=0.
  - When OUT_READY=1: without a new handshake the next state is IDLE. With a simultaneous handshake the new capture occurs (back-to-back, no bubble).
- FLUSH, highest priority after reset:
  - Next state is IDLE, OUT_VALID=0 the next cycle, and no capture happens that cycle.
  - acc is left unchanged (don't-care).
  - FLUSH in IDLE has no effect.
- Results (all shift arithmetic mod WIDTH, by construction of the SHFT width):
  - SLL: IN<<SHFT
  - SRL: IN>>SHFT
  - SRA: $signed(IN)>>>SHFT
  - ROL/ROR: rotate by SHFT
  - SEXT8/SEXT16: sign-extended value << SHFT
- Formal contracts:
  - OP!=7 at handshake.
  - IN, SHFT and OP are stable while IN_VALID && !IN_READY.
  - Assert the result equations above on OUT when OUT_VALID.
  - Assert OUT is stable while OUT_VALID && !OUT_READY.
  - Assert the latency bound.

Test Plan:
- SLL, WIDTH=32, STEP=4, IN=0x00000001, SHFT=31 -> OUT=0x80000000, OUT_VALID exactly 9 cycles after handshake; STEP=32 same stimulus -> 2 cycles.
- SRA IN=0x80000010, SHFT=5 -> OUT=0xFC000000 at latency 3. SRL same stimulus -> 0x04000000.
- ROR IN=0x12345678, SHFT=8 -> 0x78123456. ROL same stimulus -> 0x34567812. ROL SHFT=0 -> 0x12345678 at latency 1.
- SEXT8 IN=0x00000080, SHFT=4 -> 0xFFFFF800. SEXT16 IN=0x00007FFF, SHFT=0 -> 0x00007FFF.
- Backpressure, two requests:
  - Hold OUT_READY=0 for 5 cycles in DONE -> OUT stable, IN_READY=0, second request not taken.
  - Raise OUT_READY with IN_VALID=1 -> second request captured that cycle, result after its own latency.
- Abort:
  - FLUSH during SHIFT of SLL SHFT=20 -> OUT_VALID stays 0, IN_READY=1 next cycle.
  - Deassert N_RST mid-operation -> OUT=0, OUT_VALID=0 immediately. A fresh request after release completes correctly.

Source files
------------

// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq
//
// Multi-cycle shift/rotate unit between the ALU operand bus and the writeback
// bus. An operand is captured on the request handshake and then shifted by up
// to STEP bits per clock until the full shift amount is consumed. The result
// is held in DONE until the consumer takes it. A new request may be accepted
// in the same cycle the previous result leaves, so back-to-back traffic has
// no bubble.
//
// Parameters
//   WIDTH  datapath width, power of two, >= 16
//   STEP   maximum bits shifted per clock, power of two, 1..WIDTH
//
// Ports
//   CLK        clock, rising edge
//   N_RST      asynchronous active-low reset
//   FLUSH      synchronous abort of the operation in flight
//   IN_VALID   request valid
//   IN_READY   request accepted when IN_VALID && IN_READY
//   IN         operand
//   SHFT       shift amount, unsigned
//   OP         0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5 SEXT8, 6 SEXT16,
//              7 reserved (behaves as SLL)
//   OUT_VALID  result valid
//   OUT_READY  consumer accepts result
//   OUT        result register
// -----------------------------------------------------------------------------
module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     CLK,
  input  logic                     N_RST,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH-1:0]         IN,
  input  logic [$clog2(WIDTH)-1:0] SHFT,
  input  logic [2:0]               OP,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         OUT
);

  localparam int LW = $clog2(WIDTH);
  // STEP may equal WIDTH, which does not fit in LW bits; keep one spare bit.
  localparam logic [LW:0] STEP_W = (LW+1)'(STEP);

  localparam logic [2:0] OP_SRL    = 3'd1;
  localparam logic [2:0] OP_SRA    = 3'd2;
  localparam logic [2:0] OP_ROL    = 3'd3;
  localparam logic [2:0] OP_ROR    = 3'd4;
  localparam logic [2:0] OP_SEXT8  = 3'd5;
  localparam logic [2:0] OP_SEXT16 = 3'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic [LW-1:0]    n_step;
  logic [2:0]       op_q;
  logic             capture;

  // Shift by a compile-time amount k. SEXT8/SEXT16/reserved shift left.
  function automatic logic [WIDTH-1:0] shift_const(input logic [WIDTH-1:0] a,
                                                   input logic [2:0]       op,
                                                   input int               k);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    dbl = {a, a};
    case (op)
      OP_SRL:  r = a >> k;
      OP_SRA:  r = $signed(a) >>> k;
      OP_ROL: begin
        dbl = dbl << k;
        r   = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl = dbl >> k;
        r   = dbl[WIDTH-1:0];
      end
      default: r = a << k;
    endcase
    return r;
  endfunction

  // One step: a mux over the STEP+1 possible amounts rather than a full
  // barrel shifter, so the shifter logic scales with STEP, not WIDTH.
  function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] a,
                                                  input logic [2:0]       op,
                                                  input logic [LW-1:0]    n);
    logic [WIDTH-1:0] r;
    r = a;
    for (int k = 1; k <= STEP; k++) begin
      if (int'(n) == k) r = shift_const(a, op, k);
    end
    return r;
  endfunction

  // Pre-step operand value loaded on capture.
  function automatic logic [WIDTH-1:0] pre_extend(input logic [WIDTH-1:0] a,
                                                  input logic [2:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SEXT8:  r = {{(WIDTH-8){a[7]}}, a[7:0]};
      OP_SEXT16: r = {{(WIDTH-16){a[15]}}, a[15:0]};
      default:   r = a;
    endcase
    return r;
  endfunction

  assign IN_READY  = N_RST && !FLUSH &&
                     ((state_q == IDLE) || ((state_q == DONE) && OUT_READY));
  assign capture   = IN_VALID && IN_READY;
  assign OUT       = acc_q;
  assign OUT_VALID = (state_q == DONE);

  // n = min(STEP, rem)
  always_comb begin
    n_step = rem_q;
    if ({1'b0, rem_q} >= STEP_W) n_step = STEP_W[LW-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (FLUSH) begin
      // Abort: acc is left as is, its content no longer matters.
      state_d = IDLE;
    end else if (capture) begin
      acc_d   = pre_extend(IN, OP);
      rem_d   = SHFT;
      state_d = (SHFT == '0) ? DONE : SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          acc_d = step_shift(acc_q, op_q, n_step);
          rem_d = rem_q - n_step;
          if (rem_q == n_step) state_d = DONE;
        end
        DONE: begin
          if (OUT_READY) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      acc_q <= '0;
      rem_q <= '0;
      op_q  <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      if (capture) op_q <= OP;
    end
  end

  // Reserved opcode must not be issued.
  a_no_reserved_op: assert property (@(posedge CLK) disable iff (!N_RST)
    capture |-> (OP != 3'd7));

  // A result waiting for the consumer stays put unless aborted.
  a_out_hold: assert property (@(posedge CLK) disable iff (!N_RST)
    (OUT_VALID && !OUT_READY && !FLUSH) |=> (OUT_VALID && $stable(OUT)));

endmodule
